fp32_mul_normround: RTL and testbench
=====================================

# fp32_mul_normround

Two-stage pipelined normalize/round/pack stage for single-precision multiply. Consumes the 64-bit raw mantissa product from the vedic 32x32 multiplier, together with the sign, pre-biased exponent and operand class from the FPU multiply front end. Produces an IEEE-754 binary32 result plus exception flags to the FPU writeback mux. Uses a valid/ready handshake on both sides, with full throughput.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream holds a product
- in_ready  out  1  stage can accept this cycle
- in_sign  in  1  sign_a XOR sign_b
- in_exp  in  10  signed two's-complement exp_a + exp_b − 127
- in_prod  in  64  {8'b0, mant_a24} × {8'b0, mant_b24}; bits [63:48] are zero by construction
- in_class  in  2  00 normal, 01 zero, 10 inf, 11 NaN; resolved upstream
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  32  packed binary32
- out_flags  out  3  {overflow, underflow, inexact}

## Operation
- Stage 1 (normalize), registered:
  - If prod[47]=1: mant = prod[47:24], guard = prod[23], sticky = |prod[22:0], exp = in_exp + 1.
  - Otherwise: mant = prod[46:23], guard = prod[22], sticky = |prod[21:0], exp = in_exp.
  - Sign and class are carried through unchanged.
- Stage 2 (round and pack), registered:
  - Round to nearest even: increment when guard & (sticky | mant[0]).
  - If the increment carries out of 24 bits: mant = 24'h800000, exp += 1.
  - inexact = guard | sticky.
- Range checks, normal class only, applied after rounding:
  - exp ≥ 255 → {sign, 8'hFF, 23'b0}, flags = overflow | inexact.
  - exp ≤ 0 → {sign, 31'b0} (flush to zero; no subnormals), flags = underflow | inexact.
  - Otherwise → {sign, exp[7:0], mant[22:0]}, flags = {0, 0, inexact}.
- Special classes (flags = 0):
  - zero → {sign, 31'b0}.
  - inf → {sign, 8'hFF, 23'b0}.
  - NaN → 32'h7FC00000, sign ignored.
- in_prod[63:48] is ignored.

## Timing
- Latency: 2 cycles from the in_valid & in_ready edge to out_valid. Throughput: 1 result per cycle.
- Each stage holds a valid bit. A stage loads when it is empty or its contents advance the same cycle.
  - in_ready = !s1_valid | (s1 advances).
  - s1 advances = !s2_valid | out_ready.
- Full pipe with out_ready=0 → in_ready=0 combinationally the same cycle. No skid register is used.
- While out_valid & !out_ready, out_result and out_flags hold stable.
- Simultaneous accept and emit with a full pipe and out_ready=1: every stage shifts and no bubble is inserted.
- Transactions stay in order. No drop or duplicate under any ready pattern.
- Reset:
  - s1_valid, s2_valid, out_valid = 0; out_result = 0; out_flags = 0; in_ready = 1 after release.
  - An asynchronous assertion mid-operation discards in-flight items immediately.
- Data registers update only on load, to reduce toggling. Valid registers are the only state that is reset-critical.

## Configuration
- FP32_MUL_RNE_EN defined: round-to-nearest-even as above.
- Not defined: truncation. The round increment is removed; inexact, overflow and underflow are still reported; stage 2 logic shrinks.

## Structure
- Shared package fpu_pkg holds:
  - class encoding enum (FP_NORM, FP_ZERO, FP_INF, FP_NAN)
  - FP32_BIAS = 127, FP32_EXP_MAX = 255, FP32_QNAN = 32'h7FC00000
  - flag bit indices
- One combinational sub-module fp_round_rne: mant/guard/sticky/exp in → rounded mant, adjusted exp, inexact out. Reused later by the add path.
- Pipeline control (valids, ready chain) stays in the top module.

## Test plan
- 1.0×1.0: prod 64'h0000_4000_0000_0000, exp 127, class normal → 32'h3F800000, flags 0, out_valid exactly 2 cycles after accept.
- 1.5×1.5: prod 64'h0000_9000_0000_0000, exp 127 → 32'h40100000, flags 0.
- Rounding, with RNE enabled:
  - prod 64'h0000_4000_0040_0000 → 32'h3F800000, inexact (tie, even kept).
  - prod 64'h0000_4000_00C0_0000 → 32'h3F800002, inexact.
  - Truncation build: second vector → 32'h3F800001.
- Range:
  - exp 255, prod 64'h0000_4000_0000_0000, sign 1 → 32'hFF800000, flags overflow | inexact.
  - exp 0 → 32'h00000000, flags underflow | inexact.
  - class NaN → 32'h7FC00000.
- Backpressure:
  - Stream 5 back-to-back items with out_ready=0 → in_ready drops after 2 accepts.
  - Toggle out_ready randomly → all 5 results in order, each held stable while stalled.
- Reset mid-stream: assert rst_n low with both stages full → out_valid = 0 immediately. After release, in_ready = 1 and the first new item emerges after 2 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: definitions shared by the FPU datapath stages.
//   fp_class_e    : operand class that the multiply front end resolves
//   FP32_*        : binary32 format constants
//   FLAG_*        : bit positions in the 3-bit exception flag vector
//                   {overflow, underflow, inexact}
package fpu_pkg;

  typedef enum logic [1:0] {
    FP_NORM = 2'b00,
    FP_ZERO = 2'b01,
    FP_INF  = 2'b10,
    FP_NAN  = 2'b11
  } fp_class_e;

  localparam int          FP32_BIAS    = 127;
  localparam int          FP32_EXP_MAX = 255;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational mantissa rounding. The same block is meant to
// be shared with the add path.
//   mant_in   [23:0] normalized mantissa (hidden bit at [23])
//   guard_in         first bit below the mantissa lsb
//   sticky_in        OR of every bit below the guard bit
//   exp_in    [10:0] signed biased exponent
//   mant_out  [23:0] rounded mantissa
//   exp_out   [10:0] exponent, bumped when the rounding carries out
//   inexact          any discarded bit was non-zero
// Build option: FP32_MUL_RNE_EN selects round-to-nearest-even; without it
// the mantissa is truncated (inexact is still reported).
module fp_round_rne (
  input  logic               [23:0] mant_in,
  input  logic                      guard_in,
  input  logic                      sticky_in,
  input  logic signed        [10:0] exp_in,
  output logic               [23:0] mant_out,
  output logic signed        [10:0] exp_out,
  output logic                      inexact
);

  assign inexact = guard_in | sticky_in;

`ifdef FP32_MUL_RNE_EN
  logic        round_inc;
  logic [24:0] mant_sum;

  // Round up above half, or at exactly half when the lsb is odd.
  assign round_inc = guard_in & (sticky_in | mant_in[0]);
  assign mant_sum  = {1'b0, mant_in} + {24'd0, round_inc};

  always_comb begin
    mant_out = mant_sum[23:0];
    exp_out  = exp_in;
    // All-ones mantissa rounded up: renormalize to 1.0 at the next exponent.
    if (mant_sum[24]) begin
      mant_out = 24'h800000;
      exp_out  = exp_in + 11'sd1;
    end
  end
`else
  assign mant_out = mant_in;
  assign exp_out  = exp_in;
`endif

endmodule

// File: rtl/fp32_mul_normround.sv
// fp32_mul_normround: two-stage normalize / round / pack for the binary32
// multiply path. Stage 1 normalizes the raw 48-bit significand product,
// stage 2 rounds, range-checks and packs. Full-throughput valid/ready on
// both sides, no skid buffer.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_sign               product sign
//   in_exp     [9:0]      signed exp_a + exp_b - bias
//   in_prod    [63:0]     raw significand product ([63:48] unused)
//   in_class   [1:0]      fp_class_e operand class
//   out_valid / out_ready downstream handshake
//   out_result [31:0]     packed binary32
//   out_flags  [2:0]      {overflow, underflow, inexact}
// Build option: FP32_MUL_RNE_EN (see fp_round_rne) selects RNE rounding;
// undefined gives truncation.
module fp32_mul_normround
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [63:0] in_prod,
  input  logic [1:0]  in_class,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  localparam logic signed [10:0] EXP_MAX_S = 11'(FP32_EXP_MAX);

  // ---------------- pipeline control ----------------
  logic s1_valid_reg, s2_valid_reg;
  logic s1_adv, s1_load, s2_load;

  assign s1_adv   = !s2_valid_reg | out_ready;
  assign in_ready = !s1_valid_reg | s1_adv;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_adv & s1_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (in_ready) s1_valid_reg <= in_valid;
      if (s1_adv)   s2_valid_reg <= s1_valid_reg;
    end
  end

  assign out_valid = s2_valid_reg;

  // ---------------- stage 1: normalize ----------------
  logic                unused_prod_hi;
  logic                norm_shift;
  logic        [23:0]  mant_next;
  logic                guard_next, sticky_next;
  logic signed [10:0]  exp_next;

  assign unused_prod_hi = ^in_prod[63:48];

  // A product in [2,4) has its leading one at bit 47; otherwise at bit 46.
  assign norm_shift = in_prod[47];

  always_comb begin
    if (norm_shift) begin
      mant_next   = in_prod[47:24];
      guard_next  = in_prod[23];
      sticky_next = |in_prod[22:0];
    end else begin
      mant_next   = in_prod[46:23];
      guard_next  = in_prod[22];
      sticky_next = |in_prod[21:0];
    end
    // Sign-extend one bit so the +1 and the later round carry cannot wrap.
    exp_next = $signed({in_exp[9], in_exp}) + $signed({10'd0, norm_shift});
  end

  logic                s1_sign_reg;
  fp_class_e           s1_class_reg;
  logic        [23:0]  s1_mant_reg;
  logic                s1_guard_reg, s1_sticky_reg;
  logic signed [10:0]  s1_exp_reg;

  // Data registers carry no reset: only the valid bits matter after reset.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sign_reg   <= in_sign;
      s1_class_reg  <= fp_class_e'(in_class);
      s1_mant_reg   <= mant_next;
      s1_guard_reg  <= guard_next;
      s1_sticky_reg <= sticky_next;
      s1_exp_reg    <= exp_next;
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic        [23:0]  rnd_mant;
  logic signed [10:0]  rnd_exp;
  logic                rnd_inexact;

  fp_round_rne u_round (
    .mant_in   (s1_mant_reg),
    .guard_in  (s1_guard_reg),
    .sticky_in (s1_sticky_reg),
    .exp_in    (s1_exp_reg),
    .mant_out  (rnd_mant),
    .exp_out   (rnd_exp),
    .inexact   (rnd_inexact)
  );

  logic [31:0] result_next;
  logic [2:0]  flags_next;

  always_comb begin
    result_next = '0;
    flags_next  = '0;
    case (s1_class_reg)
      FP_ZERO: result_next = {s1_sign_reg, 31'b0};
      FP_INF:  result_next = {s1_sign_reg, 8'hFF, 23'b0};
      FP_NAN:  result_next = FP32_QNAN;
      default: begin
        if (rnd_exp >= EXP_MAX_S) begin
          result_next          = {s1_sign_reg, 8'hFF, 23'b0};
          flags_next[FLAG_OVF] = 1'b1;
          flags_next[FLAG_INX] = 1'b1;
        end else if (rnd_exp <= 11'sd0) begin
          // No subnormal support: anything below the normal range flushes.
          result_next          = {s1_sign_reg, 31'b0};
          flags_next[FLAG_UNF] = 1'b1;
          flags_next[FLAG_INX] = 1'b1;
        end else begin
          result_next          = {s1_sign_reg, rnd_exp[7:0], rnd_mant[22:0]};
          flags_next[FLAG_INX] = rnd_inexact;
        end
      end
    endcase
  end

  logic [31:0] out_result_reg;
  logic [2:0]  out_flags_reg;

  // Output data only changes on a load, so it stays frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_reg <= '0;
      out_flags_reg  <= '0;
    end else if (s2_load) begin
      out_result_reg <= result_next;
      out_flags_reg  <= flags_next;
    end
  end

  assign out_result = out_result_reg;
  assign out_flags  = out_flags_reg;

endmodule

// File: tb/tb_fp32_mul_normround.sv
// Testbench for fp32_mul_normround: directed vectors, scoreboard queue filled
// at accept time, independent monitor comparing every cycle a result is shown.
module tb_fp32_mul_normround;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [63:0] in_prod = '0;
  logic [1:0]  in_class = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  fp32_mul_normround dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_class   (in_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [63:0] prod;
    logic [1:0]  cls;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

`ifdef FP32_MUL_RNE_EN
  localparam logic [31:0] RND_UP_RES = 32'h3F800002;
  localparam logic [31:0] CARRY_RES  = 32'h40000000;
`else
  localparam logic [31:0] RND_UP_RES = 32'h3F800001;
  localparam logic [31:0] CARRY_RES  = 32'h3FFFFFFF;
`endif

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // Single driver of out_ready, updated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: while a result is shown it must match the queue head every
  // cycle (which also proves it holds while stalled); pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        check("result_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          check("out_result", 64'(out_result), 64'(sb_q[0].res));
          check("out_flags", 64'(out_flags), 64'(sb_q[0].flg));
          if (out_ready) begin
            $display("txn out result=%08h flags=%03b", out_result, out_flags);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input vec_t v);
    int  budget;
    bit  done;
    exp_t e;
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_prod  = v.prod;
    in_class = v.cls;
    e.res    = v.res;
    e.flg    = v.flg;
    budget   = 0;
    done     = 1'b0;
    while (!done) begin
      #4;
      if (in_ready) begin
        @(posedge clk);
        sb_q.push_back(e);
        done = 1'b1;
        @(negedge clk);
      end else begin
        @(negedge clk);
        budget++;
        if (budget > 300) begin
          checks++;
          errors++;
          $display("FAIL send_timeout actual in_ready=0 required accept within 300 cycles");
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //          sign  exp     prod                        cls    res           flg
    vecs[0]  = '{1'b0, 10'd127, 64'h0000_4000_0000_0000, 2'b00, 32'h3F800000, 3'b000}; // 1.0*1.0
    vecs[1]  = '{1'b0, 10'd127, 64'h0000_9000_0000_0000, 2'b00, 32'h40100000, 3'b000}; // 1.5*1.5
    vecs[2]  = '{1'b0, 10'd127, 64'h0000_4000_0040_0000, 2'b00, 32'h3F800000, 3'b001}; // tie, even
    vecs[3]  = '{1'b0, 10'd127, 64'h0000_4000_00C0_0000, 2'b00, RND_UP_RES,   3'b001}; // tie, odd
    vecs[4]  = '{1'b1, 10'd255, 64'h0000_4000_0000_0000, 2'b00, 32'hFF800000, 3'b101}; // overflow
    vecs[5]  = '{1'b0, 10'd0,   64'h0000_4000_0000_0000, 2'b00, 32'h00000000, 3'b011}; // underflow
    vecs[6]  = '{1'b1, 10'd127, 64'h0000_4000_0000_0000, 2'b11, 32'h7FC00000, 3'b000}; // NaN
    vecs[7]  = '{1'b1, 10'd127, 64'h0000_4000_0000_0000, 2'b01, 32'h80000000, 3'b000}; // zero
    vecs[8]  = '{1'b0, 10'd127, 64'h0000_4000_0000_0000, 2'b10, 32'h7F800000, 3'b000}; // inf
    vecs[9]  = '{1'b0, 10'd127, 64'h0000_7FFF_FFC0_0000, 2'b00, CARRY_RES,    3'b001}; // round carry
    vecs[10] = '{1'b0, 10'd254, 64'h0000_8000_0000_0000, 2'b00, 32'h7F800000, 3'b101}; // norm bump overflows
    vecs[11] = '{1'b0, 10'd254, 64'h0000_4000_0000_0000, 2'b00, 32'h7F000000, 3'b000}; // max exponent
    vecs[12] = '{1'b1, 10'd1,   64'h0000_4000_0000_0000, 2'b00, 32'h80800000, 3'b000}; // min exponent
    vecs[13] = '{1'b0, 10'h3FB, 64'h0000_4000_0000_0000, 2'b00, 32'h00000000, 3'b011}; // negative exp
    vecs[14] = '{1'b0, 10'd127, 64'hABCD_4000_0000_0000, 2'b00, 32'h3F800000, 3'b000}; // high bits ignored

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Latency: not visible one cycle after accept, visible the next.
    send(vecs[0]);
    #1;
    check("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check("lat_2cyc", 64'(out_valid), 64'd1);
    @(negedge clk);
    drain();

    // All directed vectors back to back at full rate.
    for (int i = 0; i < 15; i++) send(vecs[i]);
    drain();

    // Backpressure: with the sink stalled, two accepts fill the pipe.
    rdy_mode = 1;
    @(negedge clk);
    send(vecs[1]);
    send(vecs[3]);
    in_valid = 1'b1;
    in_sign  = vecs[4].sign;
    in_exp   = vecs[4].exp;
    in_prod  = vecs[4].prod;
    in_class = vecs[4].cls;
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #1;
    check("bp_in_ready_still_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    rdy_mode = 2;
    send(vecs[4]);
    send(vecs[9]);
    send(vecs[12]);
    drain();

    // Reset with both stages full.
    rdy_mode = 1;
    @(negedge clk);
    send(vecs[0]);
    send(vecs[1]);
    #1;
    check("mid_full_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_result", 64'(out_result), 64'd0);
    check("mid_rst_out_flags", 64'(out_flags), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    send(vecs[2]);
    #1;
    check("post_rst_lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check("post_rst_lat_2cyc", 64'(out_valid), 64'd1);
    @(negedge clk);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
